// File: rtl/host_sequencer_if.sv
// Host byte stream and core-side command bus of the host sequencer.
// The master side drives bytes, abort and ready; the slave side is the sequencer.
interface host_sequencer_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       abort;
    logic       ready;
    logic [7:0] din;
    logic [1:0] cmd;
    logic       busy;
    logic       timeout_err;

    modport master (
        output byte_in, byte_valid, abort, ready,
        input  byte_ready, din, cmd, busy, timeout_err
    );

    modport slave (
        input  byte_in, byte_valid, abort, ready,
        output byte_ready, din, cmd, busy, timeout_err
    );
endinterface

// File: rtl/host_sequencer.sv
// Collects a 16-byte plaintext and a 16-byte key from the host and replays them
// to the cipher input interface, then issues start and waits for ready.
module host_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_,
    host_sequencer_if.slave hif
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_PT    = 2'b01;
    localparam logic [1:0] CMD_KEY   = 2'b10;
    localparam logic [1:0] CMD_START = 2'b11;

    typedef enum logic [2:0] {
        S_LP = 3'd0,
        S_SP = 3'd1,
        S_LK = 3'd2,
        S_SK = 3'd3,
        S_ST = 3'd4,
        S_WT = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [127:0]        buf_q, buf_d;
    logic [7:0]          din_q, din_d;
    logic [1:0]          cmd_q, cmd_d;
    logic                byte_ready;
    logic                accept;
    logic                timeout_hit;

    // rst_ gates byte_ready so the host never sees it high while reset is held.
    assign byte_ready = rst_ && !hif.abort && ((state_q == S_LP) || (state_q == S_LK));
    assign accept     = hif.byte_valid && byte_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        buf_d       = buf_q;
        din_d       = 8'h00;
        cmd_d       = CMD_IDLE;
        timeout_hit = 1'b0;

        if (hif.abort) begin
            state_d = S_LP;
            cnt_d   = '0;
            wait_d  = '0;
            buf_d   = '0;
        end else begin
            case (state_q)
                S_LP, S_LK: begin
                    if (accept) begin
                        buf_d = {buf_q[119:0], hif.byte_in};
                        cnt_d = cnt_q + 4'd1;
                        // On the 16th byte the first byte sits just below the top
                        // slot, so it can be launched on the same edge.
                        if (cnt_q == 4'd15) begin
                            state_d = (state_q == S_LP) ? S_SP : S_SK;
                            cmd_d   = (state_q == S_LP) ? CMD_PT : CMD_KEY;
                            din_d   = buf_q[119:112];
                        end
                    end
                end

                S_SP, S_SK: begin
                    // Rotate so the top byte always matches the byte on din.
                    buf_d = {buf_q[119:0], buf_q[127:120]};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = (state_q == S_SP) ? S_LK : S_ST;
                        cmd_d   = (state_q == S_SP) ? CMD_IDLE : CMD_START;
                    end else begin
                        cmd_d = (state_q == S_SP) ? CMD_PT : CMD_KEY;
                        din_d = buf_q[119:112];
                    end
                end

                S_ST: begin
                    state_d = S_WT;
                    wait_d  = '0;
                end

                S_WT: begin
                    if (hif.ready) begin
                        state_d = S_LP;
                        wait_d  = '0;
                    end else if (wait_q == WAIT_LAST) begin
                        timeout_hit = 1'b1;
                        state_d     = S_LP;
                        wait_d      = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end

                default: begin
                    state_d = S_LP;
                    cnt_d   = '0;
                    wait_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_LP;
            cnt_q   <= '0;
            wait_q  <= '0;
            buf_q   <= '0;
            din_q   <= 8'h00;
            cmd_q   <= CMD_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            buf_q   <= buf_d;
            din_q   <= din_d;
            cmd_q   <= cmd_d;
        end
    end

    assign hif.byte_ready  = byte_ready;
    assign hif.din         = din_q;
    assign hif.cmd         = cmd_q;
    assign hif.busy        = (state_q != S_LP);
    assign hif.timeout_err = timeout_hit;

endmodule

// File: tb/tb_host_sequencer.sv
// Self-checking bench for host_sequencer: random byte streams compared against
// a block-level model of the expected send sequence and wait/timeout behaviour.
module tb_host_sequencer;
    localparam int TMO = 8;
    typedef logic [7:0] blk_t [16];

    logic clk  = 1'b0;
    logic rst_ = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [1:0] obs_cmd  [33];
    logic [7:0] obs_din  [33];
    logic       obs_busy [33];
    logic       obs_br   [33];

    host_sequencer_if hif ();

    host_sequencer #(.TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .hif  (hif)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected (cmd, din) for send cycle i counted from the cycle after the
    // 16th plaintext byte: 16 plaintext bytes, 16 key bytes, one start.
    function automatic logic [9:0] model_send(input int i, input blk_t pt, input blk_t key);
        if (i < 16) return {2'b01, pt[i]};
        if (i < 32) return {2'b10, key[i-16]};
        return {2'b11, 8'h00};
    endfunction

    task automatic rand_blk(output blk_t b);
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    endtask

    task automatic load_bytes(input blk_t b, input int n, input bit gaps, output bit ok);
        int i = 0;
        int guard = 0;
        ok = 1'b1;
        while (i < n) begin
            hif.byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            hif.byte_in    = hif.byte_valid ? b[i] : 8'($urandom);
            #1;
            if (hif.byte_valid && hif.byte_ready) i++;
            cyc();
            guard++;
            if (guard > 200) begin
                ok = 1'b0;
                break;
            end
        end
        hif.byte_valid = 1'b0;
        hif.byte_in    = 8'h00;
    endtask

    task automatic capture(input int start, input int n);
        for (int k = start; k < start + n; k++) begin
            obs_cmd[k]  = hif.cmd;
            obs_din[k]  = hif.din;
            obs_busy[k] = hif.busy;
            obs_br[k]   = hif.byte_ready;
            cyc();
        end
    endtask

    task automatic run_block(input blk_t pt, input blk_t key, input bit gaps, output bit ok);
        bit ok1, ok2;
        load_bytes(pt, 16, gaps, ok1);
        capture(0, 16);
        load_bytes(key, 16, gaps, ok2);
        capture(16, 17);
        ok = ok1 && ok2;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (hif.cmd !== 2'b00 || hif.din !== 8'h00 || hif.busy !== 1'b0 ||
            hif.byte_ready !== 1'b0 || hif.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got cmd=%b din=%02h busy=%b byte_ready=%b terr=%b, required all zero",
                     hif.cmd, hif.din, hif.busy, hif.byte_ready, hif.timeout_err);
        end
        @(posedge clk);
        @(posedge clk);
        #3 rst_ = 1'b1;
        #1;
        checks++;
        if (hif.byte_ready !== 1'b1 || hif.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got byte_ready=%b busy=%b, required byte_ready=1 busy=0",
                     hif.byte_ready, hif.busy);
        end
        cyc();
    endtask

    task automatic test_basic();
        blk_t pt, key;
        bit ok;
        logic [9:0] exp;
        for (int i = 0; i < 16; i++) begin
            pt[i]  = 8'(i);
            key[i] = 8'(i + 16);
        end
        run_block(pt, key, 1'b0, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_load: got load_ok=0, required load_ok=1");
        end
        for (int i = 0; i < 33; i++) begin
            exp = model_send(i, pt, key);
            checks++;
            if ({obs_cmd[i], obs_din[i]} !== exp || obs_busy[i] !== 1'b1 || obs_br[i] !== 1'b0) begin
                failures++;
                $display("FAIL basic_seq[%0d]: got cmd=%b din=%02h busy=%b byte_ready=%b, required cmd=%b din=%02h busy=1 byte_ready=0",
                         i, obs_cmd[i], obs_din[i], obs_busy[i], obs_br[i], exp[9:8], exp[7:0]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (hif.busy !== 1'b1 || hif.cmd !== 2'b00 || hif.din !== 8'h00 || hif.timeout_err !== 1'b0) begin
                failures++;
                $display("FAIL basic_wait[%0d]: got busy=%b cmd=%b din=%02h terr=%b, required busy=1 cmd=00 din=00 terr=0",
                         k, hif.busy, hif.cmd, hif.din, hif.timeout_err);
            end
            cyc();
        end
        hif.ready = 1'b1;
        cyc();
        hif.ready = 1'b0;
        #1;
        checks++;
        if (hif.busy !== 1'b0 || hif.byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_done: got busy=%b byte_ready=%b, required busy=0 byte_ready=1",
                     hif.busy, hif.byte_ready);
        end
    endtask

    task automatic test_gaps();
        blk_t pt, key;
        bit ok;
        logic [9:0] exp;
        rand_blk(pt);
        rand_blk(key);
        run_block(pt, key, 1'b1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL gaps_load: got load_ok=0, required load_ok=1");
        end
        for (int i = 0; i < 33; i++) begin
            exp = model_send(i, pt, key);
            checks++;
            if ({obs_cmd[i], obs_din[i]} !== exp || obs_br[i] !== 1'b0) begin
                failures++;
                $display("FAIL gaps_seq[%0d]: got cmd=%b din=%02h byte_ready=%b, required cmd=%b din=%02h byte_ready=0",
                         i, obs_cmd[i], obs_din[i], obs_br[i], exp[9:8], exp[7:0]);
            end
        end
        hif.ready = 1'b1;
        cyc();
        hif.ready = 1'b0;
    endtask

    // ready_cycle = 0 means ready never comes; otherwise the 1-based wait cycle.
    task automatic test_wait(input int ready_cycle, input string tag);
        blk_t pt, key;
        bit ok;
        int bad;
        logic exp_err;
        rand_blk(pt);
        rand_blk(key);
        run_block(pt, key, 1'b1, ok);
        bad = 0;
        for (int i = 0; i < 33; i++)
            if ({obs_cmd[i], obs_din[i]} !== model_send(i, pt, key)) bad++;
        checks++;
        if (!ok || bad != 0) begin
            failures++;
            $display("FAIL %s_stream: got load_ok=%0d bad_cycles=%0d, required load_ok=1 bad_cycles=0", tag, ok, bad);
        end
        for (int k = 1; k <= TMO; k++) begin
            hif.ready = (k == ready_cycle);
            #1;
            exp_err = (k == TMO) && (k != ready_cycle);
            checks++;
            if (hif.timeout_err !== exp_err || hif.busy !== 1'b1 || hif.cmd !== 2'b00) begin
                failures++;
                $display("FAIL %s_wait[%0d]: got terr=%b busy=%b cmd=%b, required terr=%b busy=1 cmd=00",
                         tag, k, hif.timeout_err, hif.busy, hif.cmd, exp_err);
            end
            cyc();
            if (k == ready_cycle) break;
        end
        hif.ready = 1'b0;
        #1;
        checks++;
        if (hif.busy !== 1'b0 || hif.byte_ready !== 1'b1 || hif.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_after: got busy=%b byte_ready=%b terr=%b, required busy=0 byte_ready=1 terr=0",
                     tag, hif.busy, hif.byte_ready, hif.timeout_err);
        end
    endtask

    task automatic test_ready_ignored();
        blk_t pt, key;
        bit ok;
        int bad;
        rand_blk(pt);
        rand_blk(key);
        hif.ready = 1'b1;
        run_block(pt, key, 1'b1, ok);
        bad = 0;
        for (int i = 0; i < 33; i++)
            if ({obs_cmd[i], obs_din[i]} !== model_send(i, pt, key) || obs_busy[i] !== 1'b1) bad++;
        checks++;
        if (!ok || bad != 0) begin
            failures++;
            $display("FAIL ready_ignored_stream: got load_ok=%0d bad_cycles=%0d, required load_ok=1 bad_cycles=0", ok, bad);
        end
        cyc();
        hif.ready = 1'b0;
        #1;
        checks++;
        if (hif.busy !== 1'b0) begin
            failures++;
            $display("FAIL ready_ignored_done: got busy=%b, required busy=0", hif.busy);
        end
    endtask

    task automatic test_abort();
        blk_t pt, key;
        bit ok1, ok2, ok3;
        int bad;
        rand_blk(pt);
        rand_blk(key);
        load_bytes(pt, 7, 1'b1, ok1);
        hif.abort = 1'b1;
        #1;
        checks++;
        if (hif.byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_gates_ready: got byte_ready=%b, required 0", hif.byte_ready);
        end
        cyc();
        hif.abort = 1'b0;
        load_bytes(pt, 16, 1'b0, ok2);
        capture(0, 16);
        load_bytes(key, 16, 1'b0, ok3);
        capture(16, 4);
        hif.abort = 1'b1;
        #1;
        checks++;
        if (hif.cmd !== 2'b10 || hif.din !== key[4] || hif.byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_sk5: got cmd=%b din=%02h byte_ready=%b, required cmd=10 din=%02h byte_ready=0",
                     hif.cmd, hif.din, hif.byte_ready, key[4]);
        end
        cyc();
        hif.abort = 1'b0;
        #1;
        checks++;
        if (hif.cmd !== 2'b00 || hif.din !== 8'h00 || hif.busy !== 1'b0 || hif.byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_after: got cmd=%b din=%02h busy=%b byte_ready=%b, required cmd=00 din=00 busy=0 byte_ready=1",
                     hif.cmd, hif.din, hif.busy, hif.byte_ready);
        end
        bad = 0;
        for (int i = 0; i < 20; i++)
            if ({obs_cmd[i], obs_din[i]} !== model_send(i, pt, key)) bad++;
        checks++;
        if (!ok1 || !ok2 || !ok3 || bad != 0) begin
            failures++;
            $display("FAIL abort_pre_stream: got loads_ok=%0d%0d%0d bad_cycles=%0d, required loads_ok=111 bad_cycles=0",
                     ok1, ok2, ok3, bad);
        end
        rand_blk(pt);
        rand_blk(key);
        run_block(pt, key, 1'b1, ok1);
        bad = 0;
        for (int i = 0; i < 33; i++)
            if ({obs_cmd[i], obs_din[i]} !== model_send(i, pt, key)) bad++;
        checks++;
        if (!ok1 || bad != 0) begin
            failures++;
            $display("FAIL abort_clean_stream: got load_ok=%0d bad_cycles=%0d, required load_ok=1 bad_cycles=0", ok1, bad);
        end
        hif.ready = 1'b1;
        cyc();
        hif.ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        blk_t pt, key;
        bit ok;
        int bad;
        rand_blk(pt);
        rand_blk(key);
        load_bytes(pt, 16, 1'b1, ok);
        capture(0, 3);
        bad = 0;
        for (int i = 0; i < 3; i++)
            if ({obs_cmd[i], obs_din[i]} !== model_send(i, pt, key)) bad++;
        checks++;
        if (!ok || bad != 0) begin
            failures++;
            $display("FAIL rstmid_pre: got load_ok=%0d bad_cycles=%0d, required load_ok=1 bad_cycles=0", ok, bad);
        end
        #2 rst_ = 1'b0;
        #1;
        checks++;
        if (hif.cmd !== 2'b00 || hif.din !== 8'h00 || hif.busy !== 1'b0 ||
            hif.byte_ready !== 1'b0 || hif.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: got cmd=%b din=%02h busy=%b byte_ready=%b terr=%b, required all zero",
                     hif.cmd, hif.din, hif.busy, hif.byte_ready, hif.timeout_err);
        end
        @(posedge clk);
        #4 rst_ = 1'b1;
        #1;
        checks++;
        if (hif.byte_ready !== 1'b1 || hif.busy !== 1'b0 || hif.cmd !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_release: got byte_ready=%b busy=%b cmd=%b, required byte_ready=1 busy=0 cmd=00",
                     hif.byte_ready, hif.busy, hif.cmd);
        end
        rand_blk(pt);
        rand_blk(key);
        run_block(pt, key, 1'b1, ok);
        bad = 0;
        for (int i = 0; i < 33; i++)
            if ({obs_cmd[i], obs_din[i]} !== model_send(i, pt, key)) bad++;
        checks++;
        if (!ok || bad != 0) begin
            failures++;
            $display("FAIL rstmid_clean: got load_ok=%0d bad_cycles=%0d, required load_ok=1 bad_cycles=0", ok, bad);
        end
        hif.ready = 1'b1;
        cyc();
        hif.ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        blk_t pt, key;
        bit ok;
        int bad;
        for (int n = 0; n < 3; n++) begin
            rand_blk(pt);
            rand_blk(key);
            run_block(pt, key, 1'($urandom_range(0, 1)), ok);
            bad = 0;
            for (int i = 0; i < 33; i++)
                if ({obs_cmd[i], obs_din[i]} !== model_send(i, pt, key) || obs_br[i] !== 1'b0) bad++;
            checks++;
            if (!ok || bad != 0) begin
                failures++;
                $display("FAIL b2b_stream[%0d]: got load_ok=%0d bad_cycles=%0d, required load_ok=1 bad_cycles=0", n, ok, bad);
            end
            hif.ready = 1'b1;
            cyc();
            hif.ready = 1'b0;
            #1;
            checks++;
            if (hif.busy !== 1'b0 || hif.byte_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_done[%0d]: got busy=%b byte_ready=%b, required busy=0 byte_ready=1",
                         n, hif.busy, hif.byte_ready);
            end
        end
    endtask

    initial begin
        hif.byte_in    = 8'h00;
        hif.byte_valid = 1'b0;
        hif.abort      = 1'b0;
        hif.ready      = 1'b0;
        #1 rst_ = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_wait(0, "timeout");
        test_wait(TMO, "ready_at_limit");
        test_wait(int'($urandom_range(1, TMO - 1)), "ready_early");
        test_ready_ignored();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
